// File: rtl/conv_pipe_multi.sv
// conv_pipe_multi: KxK multi-kernel convolution pipeline.
//   S1 registers per-tap products (coefficients read from the bank at acceptance),
//   S2 registers the accumulated sum, S3 rounds, clamps and drives the outputs.
//   A window presented in cycle N shows up on o_valid in cycle N+3.
//   Optional feature macro: CONV_ABS_EN (absolute value before clamp, for gradient magnitude).

// Per-tap multiplier: unsigned pixel times two's-complement coefficient.
module conv_tap_mul #(
    parameter int NBIT   = 8,
    parameter int PROD_W = 2*NBIT+1
) (
    input  logic [NBIT-1:0]          pix,
    input  logic [NBIT-1:0]          coef,
    output logic signed [PROD_W-1:0] prod
);
    // Zero-extend the pixel into signed space so the product sign follows the coefficient.
    assign prod = PROD_W'($signed({1'b0, pix})) * PROD_W'($signed(coef));
endmodule

module conv_pipe_multi #(
    parameter int NBIT        = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int FRAC_BITS   = 4,
    parameter int NUM_KERNELS = 4,
    localparam int KSEL_W     = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
    localparam int TAPS       = KERNEL_SIZE*KERNEL_SIZE
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [TAPS-1:0][NBIT-1:0] i_kernel,
    input  logic [KSEL_W-1:0]         i_kernel_wr_sel,
    input  logic                      i_kernel_valid,
    input  logic [TAPS-1:0][NBIT-1:0] i_data,
    input  logic [KSEL_W-1:0]         i_data_sel,
    input  logic                      i_data_valid,
    output logic                      o_data_ready,
    output logic [NBIT-1:0]           o_pixel,
    output logic [KSEL_W-1:0]         o_kernel_id,
    output logic                      o_sat,
    output logic                      o_valid,
    input  logic                      i_ready
);
    localparam int STAGES = 3;
    localparam int PROD_W = 2*NBIT+1;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    localparam int RW     = ACC_W + 1;  // headroom for the rounding add and negation
    localparam int RND    = (FRAC_BITS > 0) ? (1 << (FRAC_BITS-1)) : 0;
    localparam logic signed [RW-1:0] MAXV = RW'((1 << NBIT) - 1);

    logic [NUM_KERNELS-1:0][TAPS-1:0][NBIT-1:0] bank;
    logic [STAGES:1]              vld_pipe;
    logic                         stall, accept, sel_ok, wr_ok;
    logic [TAPS-1:0][NBIT-1:0]    coef_sel;
    logic signed [PROD_W-1:0]     prod    [TAPS];
    logic signed [PROD_W-1:0]     s1_prod [TAPS];
    logic [KSEL_W-1:0]            s1_kid, s2_kid;
    logic                         s1_bad, s2_bad;
    logic signed [ACC_W-1:0]      acc_sum, s2_acc;
    logic signed [RW-1:0]         rnd_sum, rounded, mag;
    logic [NBIT-1:0]              s3_pix;
    logic                         s3_sat;

    // The whole pipe freezes only when the output register holds an unaccepted result.
    assign stall        = o_valid & ~i_ready;
    assign o_data_ready = ~stall;
    assign accept       = i_data_valid & o_data_ready;
    assign o_valid      = vld_pipe[STAGES];

    // Range checks only exist when the select width can name a missing bank entry.
    generate
        if (NUM_KERNELS >= (1 << KSEL_W)) begin : g_full_bank
            assign sel_ok = 1'b1;
            assign wr_ok  = 1'b1;
        end else begin : g_part_bank
            assign sel_ok = (i_data_sel      < KSEL_W'(NUM_KERNELS));
            assign wr_ok  = (i_kernel_wr_sel < KSEL_W'(NUM_KERNELS));
        end
    endgenerate

    // Coefficients come from the bank as it stands before this edge's write.
    always_comb begin
        coef_sel = '0;
        if (sel_ok) coef_sel = bank[i_data_sel];
    end

    generate
        for (genvar g = 0; g < TAPS; g++) begin : g_tap
            conv_tap_mul #(.NBIT(NBIT), .PROD_W(PROD_W)) u_tap (
                .pix  (i_data[g]),
                .coef (coef_sel[g]),
                .prod (prod[g])
            );
        end
    endgenerate

    // Coefficient bank writes run regardless of stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                      bank <= '0;
        else if (i_kernel_valid && wr_ok)  bank[i_kernel_wr_sel] <= i_kernel;
    end

    // Adder tree over the registered tap products.
    always_comb begin
        acc_sum = '0;
        for (int t = 0; t < TAPS; t++) acc_sum = acc_sum + ACC_W'(s1_prod[t]);
    end

    // Round half up, optional magnitude, then clamp to the unsigned pixel range.
    always_comb begin
        rnd_sum = RW'(s2_acc) + RW'(RND);
        rounded = rnd_sum >>> FRAC_BITS;
`ifdef CONV_ABS_EN
        mag = (rounded < 0) ? -rounded : rounded;
`else
        mag = rounded;
`endif
        s3_pix = mag[NBIT-1:0];
        s3_sat = 1'b0;
        if (s2_bad) begin
            s3_pix = '0;
        end else if (mag < 0) begin
            s3_pix = '0;
            s3_sat = 1'b1;
        end else if (mag > MAXV) begin
            s3_pix = '1;
            s3_sat = 1'b1;
        end
    end

    // Pipeline registers: all stages advance together unless the output is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe    <= '0;
            s1_prod     <= '{default: '0};
            s1_kid      <= '0;
            s1_bad      <= 1'b0;
            s2_acc      <= '0;
            s2_kid      <= '0;
            s2_bad      <= 1'b0;
            o_pixel     <= '0;
            o_kernel_id <= '0;
            o_sat       <= 1'b0;
        end else if (!stall) begin
            vld_pipe    <= {vld_pipe[STAGES-1:1], accept};
            s1_prod     <= prod;
            s1_kid      <= i_data_sel;
            s1_bad      <= ~sel_ok;
            s2_acc      <= acc_sum;
            s2_kid      <= s1_kid;
            s2_bad      <= s1_bad;
            o_pixel     <= s3_pix;
            o_kernel_id <= s2_kid;
            o_sat       <= s3_sat;
        end
    end
endmodule

// File: tb/tb_conv_pipe_multi.sv
// Scoreboard bench for conv_pipe_multi at default parameters.
module tb_conv_pipe_multi;
    typedef logic [8:0][7:0] win_t;
    typedef struct { int pix; int sat; int kid; } exp_t;

    logic       i_clk = 0, i_rst_n = 0;
    win_t       i_kernel = '0, i_data = '0;
    logic [1:0] i_kernel_wr_sel = '0, i_data_sel = '0;
    logic       i_kernel_valid = 0, i_data_valid = 0, i_ready = 1;
    logic       o_data_ready, o_sat, o_valid;
    logic [7:0] o_pixel;
    logic [1:0] o_kernel_id;

    int   errors = 0, checks = 0, stall_cycles = 0;
    exp_t sb[$];
    logic burst_on = 0;
    int   bcyc = 0;
    logic [31:0] stall_mask = '0;

    conv_pipe_multi dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_kernel(i_kernel), .i_kernel_wr_sel(i_kernel_wr_sel), .i_kernel_valid(i_kernel_valid),
        .i_data(i_data), .i_data_sel(i_data_sel), .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready), .o_pixel(o_pixel), .o_kernel_id(o_kernel_id),
        .o_sat(o_sat), .o_valid(o_valid), .i_ready(i_ready)
    );

    initial forever #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic win_t fill(input logic [7:0] v);
        win_t w;
        for (int t = 0; t < 9; t++) w[t] = v;
        return w;
    endfunction

    // Inputs change at posedge+1; acceptance is decided by o_data_ready seen at the negedge.
    task automatic send(input win_t w, input logic [1:0] sel, input int ep, input int es);
        logic rdy;
        bit   done = 0;
        exp_t e;
        i_data = w; i_data_sel = sel; i_data_valid = 1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge i_clk); rdy = o_data_ready;
            @(posedge i_clk);
            if (rdy) begin
                e.pix = ep; e.sat = es; e.kid = int'(sel);
                sb.push_back(e);
                done = 1;
            end
            #1 i_kernel_valid = 0;
        end
        if (!done) chk("accept_timeout", 0, 1);
        i_data_valid = 0;
    endtask

    task automatic load_kernel(input win_t k, input logic [1:0] sel);
        i_kernel = k; i_kernel_wr_sel = sel; i_kernel_valid = 1;
        @(posedge i_clk); #1 i_kernel_valid = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin @(posedge i_clk); #1; n++; end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(posedge i_clk); #1;
    endtask

    // Burst i_ready pattern, applied per cycle counted from burst start.
    initial forever begin
        @(posedge i_clk); #2;
        if (burst_on) begin
            i_ready = (bcyc < 32) ? !stall_mask[bcyc] : 1'b1;
            bcyc++;
        end
    end

    // Monitor: handshake rule, stall stability, and in-order scoreboard compare.
    initial begin
        exp_t e;
        logic prev_stall = 0;
        int   prev_pix = 0, prev_kid = 0, prev_sat = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_hold_pixel", int'(o_pixel), prev_pix);
                    chk("stall_hold_kid", int'(o_kernel_id), prev_kid);
                    chk("stall_hold_sat", int'(o_sat), prev_sat);
                end
                chk("data_ready", int'(o_data_ready), int'(!(o_valid && !i_ready)));
                if (o_valid && !i_ready) stall_cycles++;
                if (o_valid && i_ready) begin
                    if (sb.size() == 0) chk("unexpected_output", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("out_pixel", int'(o_pixel), e.pix);
                        chk("out_sat", int'(o_sat), e.sat);
                        chk("out_kid", int'(o_kernel_id), e.kid);
                    end
                end
                prev_stall = o_valid && !i_ready;
                prev_pix = int'(o_pixel); prev_kid = int'(o_kernel_id); prev_sat = int'(o_sat);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        win_t k, w;
        int sob_pix, sob_sat;
        // Reset state
        repeat (3) @(posedge i_clk); #1;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_pixel", int'(o_pixel), 0);
        chk("rst_kid", int'(o_kernel_id), 0);
        chk("rst_sat", int'(o_sat), 0);
        @(negedge i_clk) i_rst_n = 1;
        @(posedge i_clk); #1;
        chk("rst_ready", int'(o_data_ready), 1);

        // Bank cleared by reset: all-zero coefficients give 0
        send(fill(8'd2), 2'd1, 0, 0);
        wait_drain();

        // Kernel 0 = 1.0 everywhere, window all 2: 2*9 = 18; latency check
        load_kernel(fill(8'd16), 2'd0);
        send(fill(8'd2), 2'd0, 18, 0);
        chk("lat_c1_valid", int'(o_valid), 0);
        @(posedge i_clk); #1; chk("lat_c2_valid", int'(o_valid), 0);
        @(posedge i_clk); #1; chk("lat_c3_valid", int'(o_valid), 1);
        wait_drain();

        // Sobel-x on a left-bright edge: acc=-2560, rounds to -160
        k = '0;
        k[0] = 8'hF0; k[2] = 8'h10; k[3] = 8'hE0; k[5] = 8'h20; k[6] = 8'hF0; k[8] = 8'h10;
        load_kernel(k, 2'd1);
        for (int r = 0; r < 3; r++) begin w[r*3] = 8'd50; w[r*3+1] = 8'd30; w[r*3+2] = 8'd10; end
`ifdef CONV_ABS_EN
        sob_pix = 160; sob_sat = 0;
`else
        sob_pix = 0; sob_sat = 1;
`endif
        send(w, 2'd1, sob_pix, sob_sat);

        // Upper clamp: 255*9 saturates
        send(fill(8'd255), 2'd0, 255, 1);

        // Kernel 2 center 0.5, center pixel 3: 1.5 rounds up to 2
        k = '0; k[4] = 8'd8;
        load_kernel(k, 2'd2);
        w = fill(8'd200); w[4] = 8'd3;
        send(w, 2'd2, 2, 0);
        wait_drain();

        // Six back-to-back windows with i_ready low in burst cycles 2..5
        stall_mask = 32'h0000_003C; stall_cycles = 0; bcyc = 0; burst_on = 1;
        for (int v = 1; v <= 6; v++) send(fill(8'(v)), 2'd0, 9*v, 0);
        wait_drain();
        burst_on = 0; i_ready = 1;
        chk("burst_stall_cycles", stall_cycles, 3);

        // Write to kernel 3 in the same cycle a sel-3 window is accepted
        i_kernel = fill(8'd16); i_kernel_wr_sel = 2'd3; i_kernel_valid = 1;
        send(fill(8'd2), 2'd3, 0, 0);
        send(fill(8'd2), 2'd3, 18, 0);
        wait_drain();

        // Reset with three windows in flight
        for (int n = 0; n < 3; n++) send(fill(8'd1), 2'd0, 9, 0);
        chk("inflight_valid", int'(o_valid), 1);
        #1 i_rst_n = 0;
        #1;
        chk("midrst_valid", int'(o_valid), 0);
        chk("midrst_pixel", int'(o_pixel), 0);
        sb.delete();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_rst_n = 1;
        @(posedge i_clk); #1;
        chk("postrst_ready", int'(o_data_ready), 1);
        for (int n = 0; n < 4; n++) begin
            chk("postrst_no_stale", int'(o_valid), 0);
            @(posedge i_clk); #1;
        end
        // Bank was cleared again by the reset
        send(fill(8'd2), 2'd0, 0, 0);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
